// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and address check for dmem_responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WAIT_CNT_W      = 4;
  localparam int ADDR_ALIGN_BITS = 2;
  localparam int WORD_BYTES      = 4;

  // An access faults when it is not word aligned or its word index is past the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[ADDR_ALIGN_BITS-1:0] != '0) ||
           ({2'b00, addr[31:ADDR_ALIGN_BITS]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 storage, byte-enabled synchronous write, combinational read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (we[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data memory responder with valid/ready request and response
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t                state;
  state_t                next_state;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic                  lat_write;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_wstrb;

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_wstrb;
  logic                  acc_err;

  logic [3:0]            arr_we;
  logic [IDX_W-1:0]      arr_idx;
  logic [31:0]           arr_rdata;

  assign accept     = req_valid && (state == IDLE);
  assign enter_resp = (state != RESP) && (next_state == RESP);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: accept in IDLE, count down in WAIT, hold RESP until the initiator takes it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt == '0) next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // With no wait states the access happens on the accepting edge, so use the live request then.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_wstrb = lat_wstrb;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end
  end

  assign acc_err = addr_err(acc_addr, DEPTH);
  assign arr_idx = acc_addr[IDX_W+1:ADDR_ALIGN_BITS];
  assign arr_we  = (enter_resp && acc_write && !acc_err) ? acc_wstrb : 4'b0000;

  // Capture the request on acceptance so later request inputs are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // Wait-state counter: loaded on accept, decremented while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Response data is sampled once on entering RESP and held until the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata <= (acc_write || acc_err) ? 32'h0 : arr_rdata;
      rsp_err   <= acc_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

endmodule
